// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage : register-file writeback stage.
//
// Retires one instruction per accept. ALU results are written on the next
// cycle. Loads park the stage in WAIT_MEM until memory returns data. The
// returned word is then byte/half/word selected and extended by funct3, and
// written on the cycle after the return.
//
// Ports
//   clk, rst      sole clock; synchronous active-high reset
//   in_valid      retiring instruction presented
//   in_ready      stage can accept (IDLE and not in reset)
//   in_rd         destination register
//   in_is_load    1 = load, 0 = ALU result
//   in_alu        ALU result
//   in_funct3     load width code
//   in_addr_lo    load byte offset
//   mem_valid     load data returned (ignored unless waiting)
//   mem_rdata     aligned word from memory
//   en4w          registered register-file write enable, one cycle per write
//   addr_w        registered write address (holds when en4w=0)
//   data_i        registered write data (holds when en4w=0)
//   load_err      one-cycle pulse: illegal funct3 or misaligned load
//
// Optional feature, macro WB_BYPASS_EN:
//   byp_valid/byp_rd/byp_data   mirror of the write port, for same-cycle
//                               forwarding into readers
//   pend_valid/pend_rd          a load to a nonzero rd is outstanding
// -----------------------------------------------------------------------------
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_is_load,
  input  logic [31:0] in_alu,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic        en4w,
  output logic [4:0]  addr_w,
  output logic [31:0] data_i,
  output logic        load_err
`ifdef WB_BYPASS_EN
  ,
  output logic        byp_valid,
  output logic [4:0]  byp_rd,
  output logic [31:0] byp_data,
  output logic        pend_valid,
  output logic [4:0]  pend_rd
`endif
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  // Fields of the outstanding load, captured at accept.
  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] lo;
  } pend_t;

  state_t      state_q, state_d;
  pend_t       pend_q, pend_d;
  logic        wen_d, err_d;
  logic [4:0]  waddr_d;
  logic [31:0] wdata_d;
  logic        accept;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] fmt_data;
  logic        fmt_err;

  assign in_ready = (state_q == IDLE) & ~rst;
  assign accept   = in_valid & in_ready;

  // Load formatting from the latched width code / offset.
  always_comb begin
    ld_byte  = 8'h0;
    ld_half  = 16'h0;
    fmt_data = 32'h0;
    fmt_err  = 1'b0;
    case (pend_q.lo)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = pend_q.lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (pend_q.f3)
      3'd0: fmt_data = {{24{ld_byte[7]}}, ld_byte};
      3'd4: fmt_data = {24'h0, ld_byte};
      3'd1: begin
        fmt_data = {{16{ld_half[15]}}, ld_half};
        fmt_err  = pend_q.lo[0];
      end
      3'd5: begin
        fmt_data = {16'h0, ld_half};
        fmt_err  = pend_q.lo[0];
      end
      3'd2: begin
        fmt_data = mem_rdata;
        fmt_err  = (pend_q.lo != 2'd0);
      end
      default: fmt_err = 1'b1;
    endcase
  end

  // Next state and next write-port values.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    wen_d   = 1'b0;
    err_d   = 1'b0;
    waddr_d = addr_w;
    wdata_d = data_i;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_is_load) begin
            pend_d  = '{rd: in_rd, f3: in_funct3, lo: in_addr_lo};
            state_d = WAIT_MEM;
          end else if (in_rd != 5'd0) begin
            wen_d   = 1'b1;
            waddr_d = in_rd;
            wdata_d = in_alu;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_valid) begin
          state_d = IDLE;
          // An illegal load reports an error and never writes, whatever rd is.
          if (fmt_err) begin
            err_d = 1'b1;
          end else if (pend_q.rd != 5'd0) begin
            wen_d   = 1'b1;
            waddr_d = pend_q.rd;
            wdata_d = fmt_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      en4w     <= 1'b0;
      addr_w   <= 5'd0;
      data_i   <= 32'h0;
      load_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      en4w     <= wen_d;
      addr_w   <= waddr_d;
      data_i   <= wdata_d;
      load_err <= err_d;
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_valid  = en4w;
  assign byp_rd     = addr_w;
  assign byp_data   = data_i;
  assign pend_valid = (state_q == WAIT_MEM) & (pend_q.rd != 5'd0);
  assign pend_rd    = pend_q.rd;
`endif

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on posedge clk.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: in_valid  in  1  retiring instruction presented; in_ready  out  1  stage accepts.
REQ-004 SHALL have: in_rd  in  5  destination register; in_is_load  in  1  1=load, 0=ALU result.
REQ-005 SHALL have: in_alu  in  32  ALU result; in_funct3  in  3  load width code; in_addr_lo  in  2  load byte offset.
REQ-006 SHALL have: mem_valid  in  1  load data returned; mem_rdata  in  32  aligned word from memory.
REQ-007 SHALL have: en4w  out  1, addr_w  out  5, data_i  out  32  register-file write port, all registered.
REQ-008 SHALL have: load_err  out  1  one-cycle pulse on illegal or misaligned load.
REQ-009 SHALL have, with WB_BYPASS_EN only: byp_valid/byp_rd[5]/byp_data[32] out; pend_valid/pend_rd[5] out.

Function
REQ-010 SHALL implement two states: IDLE, WAIT_MEM; in_ready = (state==IDLE) & ~rst.
REQ-011 Accept = in_valid & in_ready; ALU accept SHALL yield en4w=1, addr_w=in_rd, data_i=in_alu on next cycle, state stays IDLE.
REQ-012 Back-to-back ALU accepts SHALL produce one write per cycle, no bubbles.
REQ-013 Load accept SHALL latch rd/funct3/addr_lo, go WAIT_MEM; in_ready=0 until return.
REQ-014 In WAIT_MEM, mem_valid=1 SHALL format data, go IDLE; write appears next cycle, concurrent with new in_ready=1.
REQ-015 Formatting: funct3 0 lb sign-ext byte[addr_lo]; 4 lbu zero-ext; 1 lh sign-ext half[addr_lo[1]]; 5 lhu zero-ext; 2 lw whole word.
REQ-016 funct3 in {3,6,7}, lh/lhu with addr_lo[0]=1, or lw with addr_lo!=0 SHALL suppress write (en4w=0) and pulse load_err with the cycle the write would occur.
REQ-017 rd==0 SHALL force en4w=0 (transaction still completes, no load_err).
REQ-018 mem_valid while IDLE SHALL be ignored; in_valid while WAIT_MEM SHALL not be accepted.
REQ-019 en4w SHALL be high exactly one cycle per completed write; otherwise 0; addr_w/data_i hold last value when en4w=0.

Reset
REQ-020 While rst=1: state=IDLE, en4w=0, addr_w=0, data_i=0, load_err=0, in_ready=0, latched load fields cleared.
REQ-021 rst during WAIT_MEM SHALL abandon the pending load; later mem_valid SHALL not cause a write.
REQ-022 First accept SHALL be possible in the first cycle with rst=0.

Configuration
REQ-023 Macro WB_BYPASS_EN defined: byp_valid=en4w, byp_rd=addr_w, byp_data=data_i (same-cycle forwarding for readers); pend_valid=(state==WAIT_MEM)&(pend rd!=0), pend_rd=latched rd.
REQ-024 WB_BYPASS_EN undefined: byp_* and pend_* ports SHALL not exist; all other behaviour identical.

Verification
REQ-025 ALU rd=5 alu=0xDEADBEEF, then rd=6 alu=0x1 next cycle -> en4w 1 two consecutive cycles, addr_w 5 then 6, data_i 0xDEADBEEF then 0x1.
REQ-026 Load lb rd=7 addr_lo=2, mem_rdata=0x0080FF00 after 3 cycles -> in_ready 0 for 3 cycles; write rd=7 data 0xFFFFFF80; lbu same -> 0x00000080.
REQ-027 lh addr_lo=1 rd=8 -> en4w never 1, load_err pulses once; lw addr_lo=0 mem_rdata=0x12345678 -> data 0x12345678.
REQ-028 ALU rd=0 alu=0xFFFF -> en4w stays 0, load_err 0, in_ready stays 1.
REQ-029 Load rd=9, rst for 1 cycle in WAIT_MEM, then mem_valid -> no write, state IDLE, in_ready 1 after rst falls.
REQ-030 With WB_BYPASS_EN: during WAIT_MEM rd=9 -> pend_valid 1, pend_rd 9; on write cycle byp_valid 1, byp_rd 9, byp_data equals data_i.
